// File: rtl/apb_master_port.sv
// Single-outstanding APB3 initiator: valid/ready request in, one-cycle response out.
// An ACCESS-phase watchdog aborts transfers to slaves that never raise PREADY.
module apb_master_port #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      rsp_valid_o,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      write_q, write_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      ready_q, ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      rsp_tmo_q, rsp_tmo_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;

  // State register; every output is a flop so the APB and response pins are glitch-free.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state logic; response fields are set only on the transition into RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rsp_err_d   = 1'b0;
    rsp_tmo_d   = 1'b0;
    rsp_rdata_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          write_d = req_write_i;
          if (req_addr_i[1:0] != 2'b00) begin
            state_d   = S_RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d = S_SETUP;
            cnt_d   = '0;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          state_d     = S_RESP;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (!write_q && !PSLVERR) ? PRDATA : 32'h0;
        end else if (TIMEOUT_CYCLES != 0) begin
          // Counter holds the number of PREADY-low ACCESS cycles seen so far.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_MAX) begin
            state_d   = S_RESP;
            rsp_err_d = 1'b1;
            rsp_tmo_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d   = (state_d == S_ACCESS);
    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  assign req_ready_o   = ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_tmo_q;
  assign PADDR         = addr_q;
  assign PWDATA        = wdata_q;
  assign PWRITE        = write_q;
  assign PSEL          = psel_q;
  assign PENABLE       = penable_q;

endmodule

// File: tb/tb_apb_master_port.sv
// Bench for apb_master_port: offset-based transfer model checked every cycle,
// plus literal latency/result expectations per directed transfer.
module tb_apb_master_port;

  localparam int AW  = 12;
  localparam int TMO = 4;

  logic          HCLK, HRESET;
  logic          req_valid_i, req_ready_o, req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          rsp_valid_o, rsp_err_o, rsp_timeout_o;
  logic [31:0]   rsp_rdata_o;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA, PRDATA;
  logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  apb_master_port #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", nm, cyc, got, exp);
    end
  endtask

  // Current transfer description; the model derives every expected pin from it.
  bit          act = 1'b0;
  int          t0, t_waits, t_len, t_respk;
  bit          t_wr, t_slverr, t_mis, t_to;
  logic [AW-1:0] t_addr;
  logic [31:0] t_wdata, t_rdata;

  // Monitor results pinned by literal expectations.
  int          rsp_k, rsp_cnt, psel_cnt;
  logic [31:0] rsp_rd;
  logic        rsp_er, rsp_tmo;

  always @(negedge HCLK) begin : cmp
    int k;
    bit e_rv, e_bad;
    if (act) begin
      k     = cyc - t0;
      e_rv  = (k == t_respk);
      e_bad = t_mis || t_to || t_slverr;
      chk("req_ready", req_ready_o, (k == 0));
      chk("psel",      PSEL,    (!t_mis && k >= 1 && k <= 1 + t_len));
      chk("penable",   PENABLE, (!t_mis && k >= 2 && k <= 1 + t_len));
      chk("rsp_valid", rsp_valid_o, e_rv);
      chk("rsp_err",   rsp_err_o, (e_rv && e_bad));
      chk("rsp_tmo",   rsp_timeout_o, (e_rv && t_to));
      chk("rsp_rdata", rsp_rdata_o, (e_rv && !t_wr && !e_bad) ? t_rdata : 32'h0);
      if (k >= 1) begin
        chk("paddr",  32'(PADDR), 32'(t_addr));
        chk("pwdata", PWDATA, t_wdata);
        chk("pwrite", PWRITE, t_wr);
      end
      if (PSEL) psel_cnt++;
      if (rsp_valid_o) begin
        rsp_cnt++;
        rsp_k   = k;
        rsp_rd  = rsp_rdata_o;
        rsp_er  = rsp_err_o;
        rsp_tmo = rsp_timeout_o;
      end
    end else begin
      chk("idle_ready", req_ready_o, 1'b1);
      chk("idle_psel",  {PSEL, PENABLE}, 2'b00);
      chk("idle_rsp",   {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 3'b000);
      chk("idle_rdata", rsp_rdata_o, 32'h0);
    end
  end

  task automatic start_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                           input int waits, input bit se, input logic [31:0] rd);
    t_wr = wr; t_addr = addr; t_wdata = wd; t_waits = waits; t_slverr = se; t_rdata = rd;
    t_mis   = (addr[1:0] != 2'b00);
    t_to    = !t_mis && (waits < 0 || waits >= TMO);
    t_len   = t_mis ? 0 : (t_to ? TMO : waits + 1);
    t_respk = t_mis ? 1 : 2 + t_len;
    t0 = cyc; psel_cnt = 0; rsp_cnt = 0; rsp_k = -1;
    rsp_rd = 32'hx; rsp_er = 1'bx; rsp_tmo = 1'bx;
    act = 1'b1;
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_wdata_i = wd;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hDEAD_BEEF;
  endtask

  // Drive inputs for offset k; a conflicting request is held while busy and must be ignored.
  task automatic drive_offset(input int k);
    req_valid_i = (k <= t_respk);
    req_write_i = 1'b1; req_addr_i = 12'h3FC; req_wdata_i = 32'hFFFF_0000;
    PREADY  = (t_waits >= 0 && k == 2 + t_waits);
    PSLVERR = PREADY && t_slverr;
    PRDATA  = PREADY ? t_rdata : 32'hDEAD_BEEF;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge of the first idle cycle.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                         input int waits, input bit se, input logic [31:0] rd);
    start_txn(wr, addr, wd, waits, se, rd);
    for (int k = 1; k <= t_respk + 1; k++) begin
      @(posedge HCLK); #1;
      drive_offset(k);
    end
    req_valid_i = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    act = 1'b0;
  endtask

  task automatic pin(input string nm, input int k, input logic er, input logic to,
                     input logic [31:0] rd, input int pc);
    chk({nm, "_rsp_cycle"}, 32'(rsp_k), 32'(k));
    chk({nm, "_rsp_count"}, 32'(rsp_cnt), 32'd1);
    chk({nm, "_err"},  er === rsp_er ? 32'd1 : 32'd0, 32'd1);
    chk({nm, "_tmo"},  to === rsp_tmo ? 32'd1 : 32'd0, 32'd1);
    chk({nm, "_rdata"}, rsp_rd, rd);
    chk({nm, "_psel_cycles"}, 32'(psel_cnt), 32'(pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    #1;
    chk("reset_ready", req_ready_o, 1'b1);
    chk("reset_apb",   {PSEL, PENABLE, PWRITE}, 3'b000);
    chk("reset_rsp",   {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 3'b000);
    chk("reset_paddr", 32'(PADDR), 32'h0);
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(posedge HCLK); #1;

    run_txn(1'b1, 12'h000, 32'h0000_0001, 0, 1'b0, 32'h0);
    pin("wr_zero_wait", 3, 1'b0, 1'b0, 32'h0, 2);

    run_txn(1'b0, 12'h004, 32'h1111_2222, 3, 1'b0, 32'h0000_0001);
    pin("rd_3_wait", 6, 1'b0, 1'b0, 32'h0000_0001, 5);

    run_txn(1'b0, 12'h008, 32'h0, 1, 1'b1, 32'h0000_0055);
    pin("rd_slverr", 4, 1'b1, 1'b0, 32'h0, 3);
    run_txn(1'b0, 12'h00C, 32'h0, 0, 1'b0, 32'hA5A5_A5A5);
    pin("rd_back_to_back", 3, 1'b0, 1'b0, 32'hA5A5_A5A5, 2);

    run_txn(1'b0, 12'h010, 32'h0, -1, 1'b0, 32'h0BAD_0BAD);
    pin("rd_timeout", 6, 1'b1, 1'b1, 32'h0, 5);

    run_txn(1'b0, 12'h014, 32'h0, 3, 1'b0, 32'h0000_1234);
    pin("rd_ready_at_limit", 6, 1'b0, 1'b0, 32'h0000_1234, 5);

    run_txn(1'b1, 12'h018, 32'h7777_8888, 4, 1'b0, 32'h0);
    pin("wr_ready_after_limit", 6, 1'b1, 1'b1, 32'h0, 5);

    run_txn(1'b1, 12'h01C, 32'hCAFE_0001, 2, 1'b1, 32'h0);
    pin("wr_slverr", 5, 1'b1, 1'b0, 32'h0, 4);

    run_txn(1'b1, 12'h006, 32'h1234_5678, 0, 1'b0, 32'h0);
    pin("misaligned", 1, 1'b1, 1'b0, 32'h0, 0);

    // Reset in the middle of a hung ACCESS phase.
    start_txn(1'b0, 12'h040, 32'h0, -1, 1'b0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge HCLK); #1;
      drive_offset(k);
    end
    act = 1'b0;
    req_valid_i = 1'b0;
    HRESET = 1'b1;
    #1;
    chk("rst_mid_psel",    {PSEL, PENABLE}, 2'b00);
    chk("rst_mid_ready",   req_ready_o, 1'b1);
    chk("rst_mid_rsp",     rsp_valid_o, 1'b0);
    chk("rst_mid_paddr",   32'(PADDR), 32'h0);
    chk("rst_mid_accessed", 32'(psel_cnt), 32'd2);
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    run_txn(1'b0, 12'h020, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
    pin("rd_after_reset", 3, 1'b0, 1'b0, 32'hCAFE_F00D, 2);

    repeat (2) @(posedge HCLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
